// File: rtl/mips32_pkg.sv
// Shared encodings for the MIPS32 decode/execute slice: opcodes, functs,
// ALU control codes, operand-select codes and the registered control bundle.
package mips32_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_BREAK = 6'h0D;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_XOR  = 4'd3;
  localparam logic [3:0] ALU_NOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  localparam logic [1:0] SRC_RS_RT    = 2'b00;
  localparam logic [1:0] SRC_RS_IMM   = 2'b01;
  localparam logic [1:0] SRC_RT_SHAMT = 2'b10;
  localparam logic [1:0] SRC_RT_RS    = 2'b11;

  typedef struct packed {
    logic       reg_dst;
    logic       jump;
    logic       branch;
    logic       mem_to_reg;
    logic       mem_write;
    logic       reg_write;
    logic       alu_op;
    logic [1:0] alu_src;
    logic [3:0] alu_ctrl;
    logic       halt;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mips32_alu.sv
// Combinational 32-bit ALU; shifts use op2[4:0], unused codes yield zero.
module mips32_alu
  import mips32_pkg::*;
(
  input  logic [3:0]  ctrl,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic [31:0] result,
  output logic        zero
);

  // NOTE: result gets a default before the case so no path can infer a latch.
  always_comb begin
    result = '0;
    case (ctrl)
      ALU_AND:  result = op1 & op2;
      ALU_OR:   result = op1 | op2;
      ALU_ADD:  result = op1 + op2;
      ALU_XOR:  result = op1 ^ op2;
      ALU_NOR:  result = ~(op1 | op2);
      ALU_SLL:  result = op1 << op2[4:0];
      ALU_SUB:  result = op1 - op2;
      ALU_SLT:  result = ($signed(op1) < $signed(op2)) ? 32'd1 : 32'd0;
      ALU_SLTU: result = (op1 < op2) ? 32'd1 : 32'd0;
      ALU_SRL:  result = op1 >> op2[4:0];
      ALU_SRA:  result = $unsigned($signed(op1) >>> op2[4:0]);
      ALU_LUI:  result = {op2[15:0], 16'h0000};
      default:  result = '0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/mips32_decode_exec.sv
// Single-cycle MIPS32 decode/execute slice: main + ALU-control decode,
// operand muxing and ALU, with every output registered (1-cycle latency).
module mips32_decode_exec
  import mips32_pkg::*;
(
  input  logic        clock,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        reg_dst,
  output logic        jump,
  output logic        branch,
  output logic        mem_to_reg,
  output logic        mem_write,
  output logic        reg_write,
  output logic        alu_op,
  output logic [1:0]  alu_src,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] result,
  output logic        zero,
  output logic        halt,
  output logic        illegal
);

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [4:0]  w_shamt;
  logic        w_zext;
  logic [31:0] w_imm;
  logic [31:0] w_op1;
  logic [31:0] w_op2;
  logic [31:0] w_result;
  logic        w_zero;
  logic        w_unused_fields;
  ctrl_t       w_ctrl;
  ctrl_t       r_ctrl;
  logic [31:0] r_result;
  logic        r_zero;

  assign w_opcode        = instr[31:26];
  assign w_funct         = instr[5:0];
  assign w_shamt         = instr[10:6];
  assign w_unused_fields = ^instr[25:16];

  always_comb begin
    w_ctrl          = '0;
    w_ctrl.alu_ctrl = ALU_ADD;
    case (w_opcode)
      OP_RTYPE: begin
        w_ctrl.reg_dst   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_op    = 1'b1;
        case (w_funct)
          FN_ADD, FN_ADDU: w_ctrl.alu_ctrl = ALU_ADD;
          FN_SUB, FN_SUBU: w_ctrl.alu_ctrl = ALU_SUB;
          FN_AND:          w_ctrl.alu_ctrl = ALU_AND;
          FN_OR:           w_ctrl.alu_ctrl = ALU_OR;
          FN_XOR:          w_ctrl.alu_ctrl = ALU_XOR;
          FN_NOR:          w_ctrl.alu_ctrl = ALU_NOR;
          FN_SLT:          w_ctrl.alu_ctrl = ALU_SLT;
          FN_SLTU:         w_ctrl.alu_ctrl = ALU_SLTU;
          FN_SLL:  begin w_ctrl.alu_ctrl = ALU_SLL; w_ctrl.alu_src = SRC_RT_SHAMT; end
          FN_SRL:  begin w_ctrl.alu_ctrl = ALU_SRL; w_ctrl.alu_src = SRC_RT_SHAMT; end
          FN_SRA:  begin w_ctrl.alu_ctrl = ALU_SRA; w_ctrl.alu_src = SRC_RT_SHAMT; end
          FN_SLLV: begin w_ctrl.alu_ctrl = ALU_SLL; w_ctrl.alu_src = SRC_RT_RS; end
          FN_SRLV: begin w_ctrl.alu_ctrl = ALU_SRL; w_ctrl.alu_src = SRC_RT_RS; end
          FN_SRAV: begin w_ctrl.alu_ctrl = ALU_SRA; w_ctrl.alu_src = SRC_RT_RS; end
          FN_BREAK: begin w_ctrl.halt = 1'b1; w_ctrl.reg_write = 1'b0; end
          default:  begin w_ctrl.illegal = 1'b1; w_ctrl.reg_write = 1'b0; end
        endcase
      end
      OP_J:   w_ctrl.jump = 1'b1;
      OP_BEQ: begin w_ctrl.branch = 1'b1; w_ctrl.alu_ctrl = ALU_SUB; end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
      OP_LW, OP_SW: begin
        w_ctrl.alu_src   = SRC_RS_IMM;
        w_ctrl.reg_write = 1'b1;
        case (w_opcode)
          OP_SLTI:  w_ctrl.alu_ctrl = ALU_SLT;
          OP_SLTIU: w_ctrl.alu_ctrl = ALU_SLTU;
          OP_ANDI:  w_ctrl.alu_ctrl = ALU_AND;
          OP_ORI:   w_ctrl.alu_ctrl = ALU_OR;
          OP_XORI:  w_ctrl.alu_ctrl = ALU_XOR;
          OP_LUI:   w_ctrl.alu_ctrl = ALU_LUI;
          OP_LW:    w_ctrl.mem_to_reg = 1'b1;
          OP_SW:    begin w_ctrl.mem_write = 1'b1; w_ctrl.reg_write = 1'b0; end
          default:  w_ctrl.alu_ctrl = ALU_ADD;
        endcase
      end
      default: w_ctrl.illegal = 1'b1;
    endcase
  end

  // Logical immediates are zero-extended; arithmetic, compare and address ones sign-extend.
  assign w_zext = (w_opcode == OP_ANDI) || (w_opcode == OP_ORI) || (w_opcode == OP_XORI);
  assign w_imm  = w_zext ? {16'h0000, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};

  always_comb begin
    w_op1 = rs_data;
    w_op2 = rt_data;
    case (w_ctrl.alu_src)
      SRC_RS_RT:    begin w_op1 = rs_data; w_op2 = rt_data; end
      SRC_RS_IMM:   begin w_op1 = rs_data; w_op2 = w_imm; end
      SRC_RT_SHAMT: begin w_op1 = rt_data; w_op2 = {27'b0, w_shamt}; end
      SRC_RT_RS:    begin w_op1 = rt_data; w_op2 = rs_data; end
      default:      begin w_op1 = rs_data; w_op2 = rt_data; end
    endcase
  end

  mips32_alu u_alu (
    .ctrl   (w_ctrl.alu_ctrl),
    .op1    (w_op1),
    .op2    (w_op2),
    .result (w_result),
    .zero   (w_zero)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl   <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      r_ctrl   <= w_ctrl;
      r_result <= w_result;
      r_zero   <= w_zero;
    end
  end

  assign reg_dst    = r_ctrl.reg_dst;
  assign jump       = r_ctrl.jump;
  assign branch     = r_ctrl.branch;
  assign mem_to_reg = r_ctrl.mem_to_reg;
  assign mem_write  = r_ctrl.mem_write;
  assign reg_write  = r_ctrl.reg_write;
  assign alu_op     = r_ctrl.alu_op;
  assign alu_src    = r_ctrl.alu_src;
  assign alu_ctrl   = r_ctrl.alu_ctrl;
  assign halt       = r_ctrl.halt;
  assign illegal    = r_ctrl.illegal;
  assign result     = r_result;
  assign zero       = r_zero;

endmodule

// File: tb/tb_mips32_decode_exec.sv
// Directed bench for mips32_decode_exec: hand-computed vectors, inputs driven
// on the falling edge, outputs sampled 1 ns after the rising edge.
module tb_mips32_decode_exec;

  logic        clock;
  logic        rst_n;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        reg_dst, jump, branch, mem_to_reg, mem_write, reg_write, alu_op;
  logic [1:0]  alu_src;
  logic [3:0]  alu_ctrl;
  logic [31:0] result;
  logic        zero, halt, illegal;

  int n_checks = 0;
  int n_errors = 0;

  mips32_decode_exec dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .instr      (instr),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .reg_dst    (reg_dst),
    .jump       (jump),
    .branch     (branch),
    .mem_to_reg (mem_to_reg),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .alu_op     (alu_op),
    .alu_src    (alu_src),
    .alu_ctrl   (alu_ctrl),
    .result     (result),
    .zero       (zero),
    .halt       (halt),
    .illegal    (illegal)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] all_ctrl();
    return 32'({reg_dst, jump, branch, mem_to_reg, mem_write, reg_write, alu_op,
                alu_src, alu_ctrl, zero, halt, illegal});
  endfunction

  task automatic run(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clock);
    instr   = i;
    rs_data = rs;
    rt_data = rt;
    @(posedge clock);
    #1;
  endtask

  logic [31:0] seq_instr [5];
  logic [31:0] seq_rs    [5];
  logic [31:0] seq_rt    [5];
  logic [31:0] seq_exp   [5];

  initial begin
    rst_n   = 1'b0;
    instr   = 32'h00221820;
    rs_data = 32'd5;
    rt_data = 32'd7;
    #3;
    check("rst_result", result, 32'h0);
    check("rst_ctrl", all_ctrl(), 32'h0);
    @(posedge clock); #1;
    check("rst_hold_result", result, 32'h0);
    check("rst_hold_ctrl", all_ctrl(), 32'h0);
    @(negedge clock);
    rst_n = 1'b1;

    run(32'h00221820, 32'd5, 32'd7);
    check("add_result", result, 32'd12);
    check("add_reg_dst", 32'(reg_dst), 1);
    check("add_reg_write", 32'(reg_write), 1);
    check("add_zero", 32'(zero), 0);
    check("add_alu_ctrl", 32'(alu_ctrl), 2);
    check("add_alu_op", 32'(alu_op), 1);

    // Asynchronous reset asserted between clock edges.
    #2 rst_n = 1'b0;
    #1;
    check("midrst_result", result, 32'h0);
    check("midrst_ctrl", all_ctrl(), 32'h0);
    @(negedge clock);
    rst_n = 1'b1;

    run(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h22), 32'h1234, 32'h1234);
    check("sub_result", result, 32'h0);
    check("sub_zero", 32'(zero), 1);
    run(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h2A), 32'hFFFFFFFF, 32'd1);
    check("slt_result", result, 32'd1);
    run(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h2B), 32'hFFFFFFFF, 32'd1);
    check("sltu_result", result, 32'd0);
    check("sltu_zero", 32'(zero), 1);

    run(enc_r(5'd0, 5'd2, 5'd3, 5'd4, 6'h00), 32'hDEAD0000, 32'h0000000F);
    check("sll_result", result, 32'h000000F0);
    check("sll_alu_src", 32'(alu_src), 2);
    run(enc_r(5'd0, 5'd2, 5'd3, 5'd4, 6'h03), 32'h0, 32'h80000000);
    check("sra_result", result, 32'hF8000000);
    run(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h06), 32'd36, 32'h80000000);
    check("srlv_result", result, 32'h08000000);
    check("srlv_alu_src", 32'(alu_src), 3);
    run(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h27), 32'h0, 32'h0);
    check("nor_result", result, 32'hFFFFFFFF);

    run(enc_i(6'h08, 5'd1, 5'd2, 16'hFFFF), 32'd10, 32'h5555);
    check("addi_result", result, 32'd9);
    check("addi_alu_src", 32'(alu_src), 1);
    check("addi_reg_dst", 32'(reg_dst), 0);
    run(enc_i(6'h0D, 5'd1, 5'd2, 16'hFFFF), 32'd0, 32'h0);
    check("ori_result", result, 32'h0000FFFF);
    run(enc_i(6'h0C, 5'd1, 5'd2, 16'h8001), 32'hFFFFFFFF, 32'h0);
    check("andi_result", result, 32'h00008001);
    run(enc_i(6'h0F, 5'd0, 5'd2, 16'h1234), 32'hABCD, 32'h0);
    check("lui_result", result, 32'h12340000);

    run(enc_i(6'h23, 5'd1, 5'd2, 16'h0008), 32'h100, 32'h0);
    check("lw_result", result, 32'h108);
    check("lw_mem_to_reg", 32'(mem_to_reg), 1);
    check("lw_reg_write", 32'(reg_write), 1);
    run(enc_i(6'h2B, 5'd1, 5'd2, 16'hFFFC), 32'h200, 32'h77);
    check("sw_result", result, 32'h1FC);
    check("sw_mem_write", 32'(mem_write), 1);
    check("sw_reg_write", 32'(reg_write), 0);

    run(enc_i(6'h04, 5'd1, 5'd2, 16'h0010), 32'h55, 32'h55);
    check("beq_branch", 32'(branch), 1);
    check("beq_zero", 32'(zero), 1);
    check("beq_reg_write", 32'(reg_write), 0);
    run({6'h02, 26'h0000010}, 32'd3, 32'd4);
    check("j_jump", 32'(jump), 1);
    check("j_writes", 32'({reg_write, mem_write, branch}), 0);
    check("j_result", result, 32'd7);

    run(enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h0D), 32'd1, 32'd2);
    check("halt_halt", 32'(halt), 1);
    check("halt_reg_write", 32'(reg_write), 0);
    run(enc_i(6'h3F, 5'd1, 5'd2, 16'h1234), 32'd1, 32'd2);
    check("illop_illegal", 32'(illegal), 1);
    check("illop_enables", 32'({reg_write, mem_write, branch, jump}), 0);
    check("illop_alu_ctrl", 32'(alu_ctrl), 2);
    run(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F), 32'd1, 32'd2);
    check("illfn_illegal", 32'(illegal), 1);
    check("illfn_reg_write", 32'(reg_write), 0);

    // Back-to-back stream: each result must appear one edge later, not before.
    seq_instr[0] = 32'h00221820;                          seq_rs[0] = 32'd5;    seq_rt[0] = 32'd7; seq_exp[0] = 32'd12;
    seq_instr[1] = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h26);  seq_rs[1] = 32'hF0;   seq_rt[1] = 32'hFF; seq_exp[1] = 32'h0F;
    seq_instr[2] = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h23);  seq_rs[2] = 32'd3;    seq_rt[2] = 32'd5; seq_exp[2] = 32'hFFFFFFFE;
    seq_instr[3] = enc_i(6'h08, 5'd1, 5'd2, 16'h0002);    seq_rs[3] = 32'd1;    seq_rt[3] = 32'd9; seq_exp[3] = 32'd3;
    seq_instr[4] = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h25);  seq_rs[4] = 32'h0;    seq_rt[4] = 32'h0; seq_exp[4] = 32'h0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      instr   = seq_instr[k];
      rs_data = seq_rs[k];
      rt_data = seq_rt[k];
      #1;
      if (k > 0) check($sformatf("b2b_hold_%0d", k), result, seq_exp[k-1]);
      @(posedge clock);
      #1;
      check($sformatf("b2b_result_%0d", k), result, seq_exp[k]);
    end
    check("b2b_last_zero", 32'(zero), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
